risc_operand_forward_ctl: RTL and testbench

- Pipeline control block that drives the 2-bit selects of the two 16-bit 4:1 operand muxes (operand A, operand B) at the head of the RISC execute stage.
- Tracks the destination registers of the two instructions ahead of decode (EX and MEM) and chooses the operand source: regfile, EX/MEM forward, MEM/WB forward or immediate.
- Detects load-use hazards, stalls decode for one cycle and inserts a bubble.
- Keeps saturating stall and forward event counters for debug.

---
 rtl/risc_operand_forward_ctl_pkg.sv | 14 +
 rtl/risc_operand_forward_ctl_if.sv | 33 +++
 rtl/risc_operand_forward_ctl_match.sv | 17 +
 rtl/risc_operand_forward_ctl.sv | 122 ++++++++++++
 tb/tb_risc_operand_forward_ctl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/risc_operand_forward_ctl_pkg.sv
// Shared constants for the execute-stage operand forwarding control.
package risc_operand_forward_ctl_pkg;
  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  localparam int REG_AW_DEF = 3;
  localparam int ZERO_REG   = 0;

  function automatic logic is_fwd(input logic [1:0] sel);
    return (sel == SEL_EXMEM) || (sel == SEL_MEMWB);
  endfunction
endpackage

// File: rtl/risc_operand_forward_ctl_if.sv
// Decode-side fields in, operand mux selects and debug counters out.
interface risc_operand_forward_ctl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              id_use_imm;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    input  sel_a, sel_b, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_use_imm, id_rd, id_rd_we, id_is_load,
    output sel_a, sel_b, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/risc_operand_forward_ctl_match.sv
// Combinational producer/source match: a live writer of a non-zero register
// that a used source names.
module risc_fwd_match
  import risc_operand_forward_ctl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              prod_valid,
  input  logic              prod_we,
  input  logic [REG_AW-1:0] prod_rd,
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  output logic              hit
);
  assign hit = prod_valid && prod_we && (prod_rd != REG_AW'(ZERO_REG)) &&
               (prod_rd == src) && src_used;
endmodule

// File: rtl/risc_operand_forward_ctl.sv
// Operand A/B forwarding select generation, load-use stall and debug counters
// for the head of the execute stage.
module risc_operand_forward_ctl
  import risc_operand_forward_ctl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  risc_operand_forward_ctl_if.slave   bus
);
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_load_q, ex_load_d;
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;

  logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic [1:0] sel_a_c, sel_b_c;
  logic stall_c, take_c;

  risc_fwd_match #(.REG_AW(REG_AW)) u_ex_a (
    .prod_valid(ex_valid_q), .prod_we(ex_we_q), .prod_rd(ex_rd_q),
    .src(bus.id_rs1), .src_used(bus.id_rs1_used), .hit(hit_ex_a));
  risc_fwd_match #(.REG_AW(REG_AW)) u_ex_b (
    .prod_valid(ex_valid_q), .prod_we(ex_we_q), .prod_rd(ex_rd_q),
    .src(bus.id_rs2), .src_used(bus.id_rs2_used), .hit(hit_ex_b));
  risc_fwd_match #(.REG_AW(REG_AW)) u_mem_a (
    .prod_valid(mem_valid_q), .prod_we(mem_we_q), .prod_rd(mem_rd_q),
    .src(bus.id_rs1), .src_used(bus.id_rs1_used), .hit(hit_mem_a));
  risc_fwd_match #(.REG_AW(REG_AW)) u_mem_b (
    .prod_valid(mem_valid_q), .prod_we(mem_we_q), .prod_rd(mem_rd_q),
    .src(bus.id_rs2), .src_used(bus.id_rs2_used), .hit(hit_mem_b));

  // EX producer is checked first so the newer result wins.
  always_comb begin
    sel_a_c = SEL_RF;
    if (hit_ex_a)       sel_a_c = SEL_EXMEM;
    else if (hit_mem_a) sel_a_c = SEL_MEMWB;
    sel_b_c = SEL_RF;
    if (bus.id_use_imm) sel_b_c = SEL_IMM;
    else if (hit_ex_b)  sel_b_c = SEL_EXMEM;
    else if (hit_mem_b) sel_b_c = SEL_MEMWB;
  end

  // A load in EX has no result to forward yet; the consumer waits one cycle.
  assign stall_c = !bus.flush && bus.id_valid && ex_load_q &&
                   (hit_ex_a || (hit_ex_b && !bus.id_use_imm));
  assign take_c  = !bus.flush && bus.id_valid && !stall_c;

  always_comb begin
    ex_valid_d  = 1'b0;
    ex_rd_d     = ex_rd_q;
    ex_we_d     = ex_we_q;
    ex_load_d   = ex_load_q;
    mem_valid_d = 1'b0;
    mem_rd_d    = mem_rd_q;
    mem_we_d    = mem_we_q;
    sel_a_d     = SEL_RF;
    sel_b_d     = SEL_RF;
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!bus.flush) begin
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_we_d    = ex_we_q;
      if (take_c) begin
        ex_valid_d = 1'b1;
        ex_rd_d    = bus.id_rd;
        ex_we_d    = bus.id_rd_we;
        ex_load_d  = bus.id_is_load;
        sel_a_d    = sel_a_c;
        sel_b_d    = sel_b_c;
        if ((is_fwd(sel_a_c) || is_fwd(sel_b_c)) && (fwd_cnt_q != '1))
          fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
    end
    if (stall_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.sel_a     = sel_a_q;
  assign bus.sel_b     = sel_b_q;
  assign bus.stall     = stall_c;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
endmodule

// File: tb/tb_risc_operand_forward_ctl.sv
// Directed scenarios plus random traffic against a small instruction-slot model.
module tb_risc_operand_forward_ctl;
  localparam int RW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    bit valid; int rs1; int rs2; bit u1; bit u2; bit imm;
    int rd; bit we; bit load;
  } inst_t;

  typedef struct { bit valid; int rd; bit we; bit load; } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  risc_operand_forward_ctl_if #(.REG_AW(RW), .CNT_W(CW)) bus();
  risc_operand_forward_ctl #(.REG_AW(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  slot_t m_ex, m_mem;
  int m_sel_a, m_sel_b, m_stall_cnt, m_fwd_cnt;
  bit last_stall;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input slot_t s, input int src, input bit used);
    return s.valid && s.we && s.rd != 0 && s.rd == src && used;
  endfunction

  function automatic int pick(input int src, input bit used);
    if (writes(m_ex, src, used))  return 1;
    if (writes(m_mem, src, used)) return 2;
    return 0;
  endfunction

  function automatic inst_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                               input bit imm, input int rd, input bit we, input bit load);
    inst_t i;
    i.valid = 1; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    i.imm = imm; i.rd = rd; i.we = we; i.load = load;
    return i;
  endfunction

  function automatic inst_t nop();
    inst_t i;
    i = mk(0, 0, 0, 0, 0, 0, 0, 0);
    i.valid = 0;
    return i;
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    m_sel_a = 0; m_sel_b = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
  endtask

  // Called at posedge+1: drive, check stall mid-cycle, clock, check registered outputs.
  task automatic cycle(input inst_t in, input bit fl);
    bit exp_stall;
    int sa, sb;
    bus.flush = fl; bus.id_valid = in.valid;
    bus.id_rs1 = RW'(in.rs1); bus.id_rs2 = RW'(in.rs2);
    bus.id_rs1_used = in.u1; bus.id_rs2_used = in.u2; bus.id_use_imm = in.imm;
    bus.id_rd = RW'(in.rd); bus.id_rd_we = in.we; bus.id_is_load = in.load;
    #2;
    exp_stall = !fl && in.valid && m_ex.load &&
                (writes(m_ex, in.rs1, in.u1) || (!in.imm && writes(m_ex, in.rs2, in.u2)));
    last_stall = bus.stall;
    chk("stall", int'(bus.stall), int'(exp_stall));
    sa = pick(in.rs1, in.u1);
    sb = in.imm ? 3 : pick(in.rs2, in.u2);
    @(posedge clk);
    if (exp_stall) m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
    if (fl) begin
      m_ex.valid = 0; m_mem.valid = 0; m_sel_a = 0; m_sel_b = 0;
    end else begin
      m_mem = m_ex;
      if (in.valid && !exp_stall) begin
        m_ex = '{1, in.rd, in.we, in.load};
        m_sel_a = sa; m_sel_b = sb;
        if (sa == 1 || sa == 2 || sb == 1 || sb == 2)
          m_fwd_cnt = (m_fwd_cnt < CMAX) ? m_fwd_cnt + 1 : CMAX;
      end else begin
        m_ex.valid = 0; m_sel_a = 0; m_sel_b = 0;
      end
    end
    #1;
    chk("sel_a", int'(bus.sel_a), m_sel_a);
    chk("sel_b", int'(bus.sel_b), m_sel_b);
    chk("stall_cnt", int'(bus.stall_cnt), m_stall_cnt);
    chk("fwd_cnt", int'(bus.fwd_cnt), m_fwd_cnt);
  endtask

  initial begin
    inst_t ri;
    bus.flush = 0; bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_use_imm = 0;
    bus.id_rd = '0; bus.id_rd_we = 0; bus.id_is_load = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", int'(bus.sel_a), 0);
    chk("rst_sel_b", int'(bus.sel_b), 0);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_cnts", int'({bus.stall_cnt, bus.fwd_cnt}), 0);
    rst_n = 1'b1;

    // Back-to-back ALU dependency
    cycle(mk(2, 1, 3, 1, 0, 1, 1, 0), 0);
    cycle(mk(1, 1, 3, 1, 0, 2, 1, 0), 0);
    chk("b2b_sel_a", int'(bus.sel_a), 1);
    chk("b2b_sel_b", int'(bus.sel_b), 0);
    chk("b2b_stall", int'(last_stall), 0);
    chk("b2b_fwd", int'(bus.fwd_cnt), 1);

    // Distance-two dependency on both operands
    cycle(mk(5, 1, 6, 1, 0, 1, 1, 0), 0);
    cycle(nop(), 0);
    cycle(mk(1, 1, 1, 1, 0, 4, 1, 0), 0);
    chk("d2_sel_a", int'(bus.sel_a), 2);
    chk("d2_sel_b", int'(bus.sel_b), 2);

    // Load-use with immediate on B
    cycle(mk(3, 1, 0, 0, 0, 2, 1, 1), 0);
    cycle(mk(2, 1, 0, 0, 1, 5, 1, 0), 0);
    chk("lu_stall", int'(last_stall), 1);
    chk("lu_bubble", int'({bus.sel_a, bus.sel_b}), 0);
    cycle(mk(2, 1, 0, 0, 1, 5, 1, 0), 0);
    chk("lu_stall2", int'(last_stall), 0);
    chk("lu_sel_a", int'(bus.sel_a), 2);
    chk("lu_sel_b", int'(bus.sel_b), 3);
    chk("lu_scnt", int'(bus.stall_cnt), 1);

    // r0 never forwards, even from a load
    cycle(mk(4, 1, 0, 0, 0, 0, 1, 1), 0);
    cycle(mk(0, 1, 0, 1, 0, 6, 1, 0), 0);
    chk("r0_stall", int'(last_stall), 0);
    chk("r0_sel_a", int'(bus.sel_a), 0);

    // Flush kills the producer
    cycle(mk(5, 1, 6, 1, 0, 1, 1, 0), 0);
    cycle(nop(), 1);
    cycle(mk(1, 1, 0, 0, 0, 7, 1, 0), 0);
    chk("fl_sel_a", int'(bus.sel_a), 0);

    // Reset dropped during a load-use stall
    cycle(mk(4, 1, 0, 0, 0, 3, 1, 1), 0);
    bus.id_valid = 1; bus.id_rs1 = RW'(3); bus.id_rs1_used = 1;
    bus.id_rs2_used = 0; bus.id_use_imm = 0; bus.flush = 0;
    #2;
    chk("pre_rst_stall", int'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", int'(bus.stall), 0);
    chk("rst_mid_sel", int'({bus.sel_a, bus.sel_b}), 0);
    chk("rst_mid_cnt", int'(bus.stall_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Saturate the stall counter
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      cycle(mk(2, 1, 0, 0, 0, 1, 1, 1), 0);
      cycle(mk(1, 1, 2, 1, 0, 3, 1, 0), 0);
      cycle(mk(1, 1, 2, 1, 0, 3, 1, 0), 0);
    end
    chk("sat_stall_cnt", int'(bus.stall_cnt), 4'hF);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      ri = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0));
      ri.valid = ($urandom_range(0, 4) != 0);
      cycle(ri, ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
